control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Multi-cycle sequencer for the 16-bit RISC core. Steps each instruction through
//  FETCH, DECODE, REGREAD, ALU, optional MEM and WRITEBACK, and drives the one-cycle
//  stage enables for fetch, decoder, regfile, alu, data memory and PC unit.
//  Handles the memory ready handshake with a wait timeout and turns the ALU branch
//  flag into the PC update command. Sits at core top level beside alu/regfile/pc_unit.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles waiting for I_mem_ready before fault (1..65535)
//  TMR_W        16   width of wait counter; must hold MEM_TIMEOUT
// PORTS
//  I_clk          in   1  core clock; all state on rising edge
//  I_rst          in   1  reset, synchronous, active-high
//  I_aluop        in   5  decoded {opcode[3:0], op_lsb} from decoder, valid from REGREAD on
//  I_shldBranch   in   1  branch flag from alu, valid at rising edge ending ALU
//  I_mem_ready    in   1  memory handshake: access complete this cycle
//  O_en_fetch     out  1  fetch stage enable
//  O_en_decode    out  1  decoder enable
//  O_en_regread   out  1  regfile read enable
//  O_en_alu       out  1  alu I_en (alu samples on falling edge inside this cycle)
//  O_en_regwrite  out  1  regfile write enable
//  O_mem_req      out  1  memory request, held until I_mem_ready
//  O_mem_we       out  1  memory write strobe, qualifies O_mem_req
//  O_pc_op        out  2  00 hold, 01 increment, 10 load branch target, 11 reset
//  O_state        out  4  current state code, for debug
//  O_fault        out  1  sticky memory-timeout fault
// BEHAVIOUR
//  - Moore outputs, decoded from the state register and latched opcode only.
//  - Reset: I_rst high at a rising edge -> S_RESET, counter 0, O_fault 0. I_rst beats
//    every other event, including mid-wait and FAULT. In S_RESET all enables/req/we = 0
//    and O_pc_op = 11. Next state after S_RESET is FETCH.
//  - FETCH: O_en_fetch=1, O_mem_req=1, O_mem_we=0. Stays while I_mem_ready=0.
//    Goes to DECODE on the edge where I_mem_ready=1.
//  - DECODE: O_en_decode=1 for one cycle. Then REGREAD.
//  - REGREAD: O_en_regread=1. I_aluop is latched into r_op at the end of this cycle.
//    Then ALU.
//  - ALU: O_en_alu=1 for exactly one cycle. Next state is MEM if r_op opcode=14
//    (LDM/STM), else WRITEBACK.
//  - MEM: O_mem_req=1, O_mem_we=r_op[0] (1 = store). Waits for I_mem_ready like FETCH.
//    Then WRITEBACK.
//  - WRITEBACK: O_en_regwrite=1, except JMPA(12), JMPR(13) and STM (op 14, lsb 1).
//    O_pc_op=10 if the I_shldBranch captured at the end of ALU is 1, else 01.
//    Then FETCH. Minimum CPI: 5 (no MEM), 6 (MEM), plus wait cycles.
//  - Wait counter: cleared on entry to FETCH/MEM; increments each cycle with
//    I_mem_ready=0. If count reaches MEM_TIMEOUT -> FAULT. If I_mem_ready=1 on the
//    same edge the count reaches MEM_TIMEOUT, the ready wins.
//  - FAULT: all enables/req = 0, O_pc_op=00, O_fault=1. Leaves only through I_rst.
//  - Opcodes 6, 7, 15: treated as no-op; regwrite suppressed, PC increments.
//  - Unused state codes decode to S_RESET behaviour and go to FETCH next edge.
// STRUCTURE
//  - risc16_pkg (shared): opcode localparams (Add..JMPR, MEM=14), state codes,
//    PC_OP_* codes. The alu is migrated to the same opcode constants.
//  - Sub-module mem_wait_timer (clear, count, expired): one instance, used by both
//    wait states.
// TESTING
//  1. I_rst=1 for 2 cycles, then 0, I_mem_ready=1 -> S_RESET with O_pc_op=11, then
//     FETCH, DECODE, REGREAD, ALU, WB; all enables one-hot.
//  2. ADD (aluop 5'b00000), ready always 1 -> 5-cycle loop; WB has regwrite=1, pc_op=01.
//  3. JMPA (5'b11000), I_shldBranch=1 -> WB has regwrite=0, pc_op=10.
//  4. STM (5'b11101), ready low 3 cycles in MEM -> mem_req=1, we=1 for 4 cycles;
//     WB regwrite=0; LDM (5'b11100) -> we=0, regwrite=1.
//  5. MEM_TIMEOUT=4, ready held 0 in FETCH -> FAULT after 4 wait cycles, O_fault=1,
//     stays there; ready on 4th cycle -> DECODE instead.
//  6. I_rst asserted mid-MEM wait and in FAULT -> S_RESET next edge, O_fault=0,
//     mem_req dropped.

Source files
------------

// File: rtl/risc16_pkg.sv
// risc16_pkg
//   Shared constants for the 16-bit RISC core: 4-bit opcode values,
//   control_unit state codes and PC unit command codes.
//   Also holds the small opcode classification helpers used by the
//   sequencer when it decides on register writeback and PC update.
//   No ports (package).
package risc16_pkg;

    // Opcodes (upper four bits of the decoded aluop).
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_RSV6  = 4'd6;
    localparam logic [3:0] OP_RSV7  = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;
    localparam logic [3:0] OP_CMP   = 4'd10;
    localparam logic [3:0] OP_LDI   = 4'd11;
    localparam logic [3:0] OP_JMPA  = 4'd12;
    localparam logic [3:0] OP_JMPR  = 4'd13;
    localparam logic [3:0] OP_MEM   = 4'd14;  // LDM (lsb 0) / STM (lsb 1)
    localparam logic [3:0] OP_RSV15 = 4'd15;

    // Sequencer state codes, visible on O_state.
    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_REGREAD   = 4'd3,
        S_ALU       = 4'd4,
        S_MEM       = 4'd5,
        S_WRITEBACK = 4'd6,
        S_FAULT     = 4'd7
    } cu_state_t;

    // PC unit commands.
    localparam logic [1:0] PC_OP_HOLD   = 2'b00;
    localparam logic [1:0] PC_OP_INC    = 2'b01;
    localparam logic [1:0] PC_OP_BRANCH = 2'b10;
    localparam logic [1:0] PC_OP_RESET  = 2'b11;

    // Reserved opcodes execute as no-ops.
    function automatic logic op_is_nop(input logic [3:0] opc);
        return (opc == OP_RSV6) || (opc == OP_RSV7) || (opc == OP_RSV15);
    endfunction

    // True when the instruction writes a result into the register file.
    // Jumps, stores and no-ops leave the register file untouched.
    function automatic logic op_writes_reg(input logic [4:0] aluop);
        logic [3:0] opc;
        opc = aluop[4:1];
        if (op_is_nop(opc))                      return 1'b0;
        if (opc == OP_JMPA || opc == OP_JMPR)    return 1'b0;
        if (opc == OP_MEM && aluop[0])           return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
//   Counts cycles spent waiting for the memory handshake and flags when the
//   wait budget is used up. Shared by the FETCH and MEM wait states.
// Ports
//   clk      in   1  clock, rising edge
//   rst      in   1  synchronous active-high reset, clears the count
//   clear    in   1  hold count at zero (asserted outside the wait states)
//   count    in   1  one more wait cycle elapses at this edge
//   expired  out  1  this edge would bring the count to TIMEOUT
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Looks one edge ahead so the FSM can leave for FAULT on the same edge
    // the count reaches TIMEOUT; the FSM gives ready priority over this.
    assign expired = count && (cnt == LAST);

endmodule

// File: rtl/control_unit.sv
// control_unit
//   Multi-cycle sequencer for the 16-bit RISC core. Walks each instruction
//   through FETCH, DECODE, REGREAD, ALU, optional MEM and WRITEBACK and raises
//   one-cycle stage enables. Memory waits are bounded by MEM_TIMEOUT; running
//   out leaves the core parked in FAULT until reset.
// Ports
//   I_clk          in   1  core clock
//   I_rst          in   1  synchronous active-high reset
//   I_aluop        in   5  {opcode, op_lsb} from decoder, valid in REGREAD
//   I_shldBranch   in   1  branch flag from alu, valid at the edge ending ALU
//   I_mem_ready    in   1  memory access completes this cycle
//   O_en_fetch     out  1  fetch enable
//   O_en_decode    out  1  decoder enable
//   O_en_regread   out  1  regfile read enable
//   O_en_alu       out  1  alu enable
//   O_en_regwrite  out  1  regfile write enable
//   O_mem_req      out  1  memory request, held until I_mem_ready
//   O_mem_we       out  1  memory write strobe
//   O_pc_op        out  2  PC command (hold/inc/branch/reset)
//   O_state        out  4  current state code
//   O_fault        out  1  memory-timeout fault
//
// Handshake: in FETCH and MEM the request is held high every cycle until a
// cycle in which I_mem_ready is 1; the access completes at the rising edge
// ending that cycle and the sequencer advances on that same edge.
module control_unit
    import risc16_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TMR_W       = 16
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic [4:0] I_aluop,
    input  logic       I_shldBranch,
    input  logic       I_mem_ready,
    output logic       O_en_fetch,
    output logic       O_en_decode,
    output logic       O_en_regread,
    output logic       O_en_alu,
    output logic       O_en_regwrite,
    output logic       O_mem_req,
    output logic       O_mem_we,
    output logic [1:0] O_pc_op,
    output logic [3:0] O_state,
    output logic       O_fault
);

    cu_state_t  state;
    cu_state_t  state_next;
    logic [4:0] r_op;
    logic       r_branch;
    logic       in_wait;
    logic       wait_expired;

    assign in_wait = (state == S_FETCH) || (state == S_MEM);

    // Held clear outside the wait states, so it always starts a wait at zero.
    mem_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT),
        .W       (TMR_W)
    ) u_wait_timer (
        .clk     (I_clk),
        .rst     (I_rst),
        .clear   (!in_wait),
        .count   (in_wait && !I_mem_ready),
        .expired (wait_expired)
    );

    // State register.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Instruction context: opcode captured leaving REGREAD, branch flag
    // captured leaving ALU, both used later in the instruction.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_op     <= '0;
            r_branch <= 1'b0;
        end else begin
            if (state == S_REGREAD) begin
                r_op <= I_aluop;
            end
            if (state == S_ALU) begin
                r_branch <= I_shldBranch;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH: begin
                if (I_mem_ready)       state_next = S_DECODE;
                else if (wait_expired) state_next = S_FAULT;
                else                   state_next = S_FETCH;
            end
            S_DECODE:    state_next = S_REGREAD;
            S_REGREAD:   state_next = S_ALU;
            S_ALU: begin
                if (r_op[4:1] == OP_MEM) state_next = S_MEM;
                else                     state_next = S_WRITEBACK;
            end
            S_MEM: begin
                if (I_mem_ready)       state_next = S_WRITEBACK;
                else if (wait_expired) state_next = S_FAULT;
                else                   state_next = S_MEM;
            end
            S_WRITEBACK: state_next = S_FETCH;
            S_FAULT:     state_next = S_FAULT;
            default:     state_next = S_FETCH;  // S_RESET and unused codes
        endcase
    end

    // Moore outputs from the state register and latched context only.
    always_comb begin
        O_en_fetch    = 1'b0;
        O_en_decode   = 1'b0;
        O_en_regread  = 1'b0;
        O_en_alu      = 1'b0;
        O_en_regwrite = 1'b0;
        O_mem_req     = 1'b0;
        O_mem_we      = 1'b0;
        O_pc_op       = PC_OP_HOLD;
        O_fault       = 1'b0;
        case (state)
            S_FETCH: begin
                O_en_fetch = 1'b1;
                O_mem_req  = 1'b1;
            end
            S_DECODE:  O_en_decode  = 1'b1;
            S_REGREAD: O_en_regread = 1'b1;
            S_ALU:     O_en_alu     = 1'b1;
            S_MEM: begin
                O_mem_req = 1'b1;
                O_mem_we  = r_op[0];
            end
            S_WRITEBACK: begin
                O_en_regwrite = op_writes_reg(r_op);
                // No-ops always step the PC, whatever the alu flagged.
                if (r_branch && !op_is_nop(r_op[4:1])) O_pc_op = PC_OP_BRANCH;
                else                                   O_pc_op = PC_OP_INC;
            end
            S_FAULT: O_fault = 1'b1;
            default: O_pc_op = PC_OP_RESET;  // S_RESET and unused codes
        endcase
    end

    assign O_state = state;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  localparam int unsigned TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] aluop;
  logic       branch;
  logic       ready;
  logic       en_fetch, en_decode, en_regread, en_alu, en_regwrite;
  logic       mem_req, mem_we, fault;
  logic [1:0] pc_op;
  logic [3:0] state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  control_unit #(.MEM_TIMEOUT(TIMEOUT), .TMR_W(8)) dut (
    .I_clk         (clk),
    .I_rst         (rst),
    .I_aluop       (aluop),
    .I_shldBranch  (branch),
    .I_mem_ready   (ready),
    .O_en_fetch    (en_fetch),
    .O_en_decode   (en_decode),
    .O_en_regread  (en_regread),
    .O_en_alu      (en_alu),
    .O_en_regwrite (en_regwrite),
    .O_mem_req     (mem_req),
    .O_mem_we      (mem_we),
    .O_pc_op       (pc_op),
    .O_state       (state),
    .O_fault       (fault)
  );

  // ---------------- scoreboard ----------------
  // Output vector: {state, fetch, decode, regread, alu, regwrite, req, we, pc_op, fault}
  logic [13:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [13:0] act;

  assign act = {state, en_fetch, en_decode, en_regread, en_alu, en_regwrite,
                mem_req, mem_we, pc_op, fault};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [13:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s at %0t: actual=%b required=%b", t, $time, act, e);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [13:0] vec(input logic [3:0] st, input logic [6:0] en,
                                      input logic [1:0] pc, input logic flt);
    return {st, en, pc, flt};
  endfunction

  function automatic logic [13:0] v_reset();   return vec(4'd0, 7'b0000000, 2'b11, 1'b0); endfunction
  function automatic logic [13:0] v_fetch();   return vec(4'd1, 7'b1000010, 2'b00, 1'b0); endfunction
  function automatic logic [13:0] v_decode();  return vec(4'd2, 7'b0100000, 2'b00, 1'b0); endfunction
  function automatic logic [13:0] v_regread(); return vec(4'd3, 7'b0010000, 2'b00, 1'b0); endfunction
  function automatic logic [13:0] v_alu();     return vec(4'd4, 7'b0001000, 2'b00, 1'b0); endfunction
  function automatic logic [13:0] v_fault();   return vec(4'd7, 7'b0000000, 2'b00, 1'b1); endfunction
  function automatic logic [13:0] v_mem(input logic we);
    return vec(4'd5, {5'b00000, 1'b1, we}, 2'b00, 1'b0);
  endfunction
  function automatic logic [13:0] v_wb(input logic w, input logic [1:0] pc);
    return vec(4'd6, {4'b0000, w, 2'b00}, pc, 1'b0);
  endfunction

  function automatic logic model_regwrite(input logic [4:0] op);
    int opc;
    opc = int'(op[4:1]);
    if (opc == 6 || opc == 7 || opc == 12 || opc == 13 || opc == 15) return 1'b0;
    if (opc == 14) return !op[0];
    return 1'b1;
  endfunction

  function automatic logic [1:0] model_pc(input logic [4:0] op, input logic br);
    int opc;
    opc = int'(op[4:1]);
    if (opc == 6 || opc == 7 || opc == 15) return 2'b01;
    return br ? 2'b10 : 2'b01;
  endfunction

  // ---------------- driver ----------------
  function automatic logic rbit();  return 1'($urandom_range(0, 1));  endfunction
  function automatic logic [4:0] rop(); return 5'($urandom_range(0, 31)); endfunction

  // Drive one cycle of inputs and record what the DUT must show in that cycle.
  task automatic step(input logic r_in, input logic rdy, input logic br,
                      input logic [4:0] op, input logic [13:0] e, input string tag);
    rst    = r_in;
    ready  = rdy;
    branch = br;
    aluop  = op;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // One memory wait phase. outcome: 0 completed, 1 reset during wait, 2 timed out.
  task automatic do_wait(input logic [13:0] v, input int waits, input int rst_at,
                         input string tag, output int outcome);
    outcome = 0;
    for (int i = 0; ; i++) begin
      if (i == rst_at) begin
        step(1'b1, 1'b0, rbit(), rop(), v, "wait_rst");
        step(1'b0, rbit(), rbit(), rop(), v_reset(), "reset_after_wait");
        outcome = 1;
        return;
      end
      if (i == int'(TIMEOUT)) begin
        for (int k = 0; k < 3; k++) step(1'b0, rbit(), rbit(), rop(), v_fault(), "fault_hold");
        step(1'b1, rbit(), rbit(), rop(), v_fault(), "fault_rst");
        step(1'b0, rbit(), rbit(), rop(), v_reset(), "reset_after_fault");
        outcome = 2;
        return;
      end
      step(1'b0, (i == waits), rbit(), rop(), v, tag);
      if (i == waits) return;
    end
  endtask

  task automatic run_instr(input logic [4:0] op, input logic br, input int fw,
                           input int mw, input int frst, input int mrst);
    int outcome;
    do_wait(v_fetch(), fw, frst, "fetch", outcome);
    if (outcome != 0) return;
    step(1'b0, rbit(), rbit(), rop(), v_decode(), "decode");
    step(1'b0, rbit(), rbit(), op, v_regread(), "regread");
    step(1'b0, rbit(), br, rop(), v_alu(), "alu");
    if (op[4:1] == 4'd14) begin
      do_wait(v_mem(op[0]), mw, mrst, "mem", outcome);
      if (outcome != 0) return;
    end
    step(1'b0, rbit(), rbit(), rop(), v_wb(model_regwrite(op), model_pc(op, br)), "writeback");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; ready = 1'b0; branch = 1'b0; aluop = '0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 1'b0, 5'd0, v_reset(), "reset_hold");
    step(1'b0, 1'b1, 1'b0, 5'd0, v_reset(), "reset_exit");

    // Directed cases.
    run_instr(5'b00000, 1'b0, 0, 0, -1, -1);           // ADD
    run_instr(5'b00000, 1'b0, 0, 0, -1, -1);           // ADD again
    run_instr(5'b11000, 1'b1, 0, 0, -1, -1);           // JMPA taken
    run_instr(5'b11101, 1'b0, 0, 3, -1, -1);           // STM, 3 wait cycles
    run_instr(5'b11100, 1'b0, 1, 1, -1, -1);           // LDM
    run_instr(5'b01100, 1'b1, 0, 0, -1, -1);           // reserved op 6 with branch flag
    run_instr(5'b11110, 1'b1, 0, 0, -1, -1);           // reserved op 15
    run_instr(5'b00010, 1'b1, TIMEOUT - 1, 0, -1, -1); // ready on last allowed fetch cycle
    run_instr(5'b11101, 1'b0, 0, TIMEOUT - 1, -1, -1); // ready on last allowed mem cycle
    run_instr(5'b00000, 1'b0, TIMEOUT, 0, -1, -1);     // fetch timeout -> FAULT -> reset
    run_instr(5'b11101, 1'b0, 0, 5, -1, 2);            // reset during MEM wait
    run_instr(5'b11100, 1'b0, 0, TIMEOUT, -1, -1);     // mem timeout -> FAULT -> reset
    run_instr(5'b10100, 1'b0, 2, 0, 1, -1);            // reset during FETCH wait

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      logic [4:0] op;
      int fw, mw, frst, mrst;
      op = rop();
      if ($urandom_range(0, 3) == 0) op[4:1] = 4'd14;
      fw = $urandom_range(0, TIMEOUT - 1);
      mw = $urandom_range(0, TIMEOUT - 1);
      frst = -1;
      mrst = -1;
      case ($urandom_range(0, 19))
        0: fw = TIMEOUT;
        1: mw = TIMEOUT;
        2: frst = $urandom_range(0, fw);
        3: mrst = $urandom_range(0, mw);
        default: ;
      endcase
      run_instr(op, rbit(), fw, mw, frst, mrst);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
